// File: rtl/pipe_mux.sv
// -----------------------------------------------------------------------------
// pipe_mux
//
// Registered N:1 channel multiplexer with a one-entry valid/ready output stage.
// The channel is chosen either explicitly (mode=0, from sel) or by an internal
// round-robin pointer (mode=1). An explicit select that names a channel that
// does not exist (only possible when NUM_IN is not a power of two) is refused
// and latched into a sticky error flag.
//
// Parameters
//   WIDTH      bit width of each data channel (>= 1)
//   NUM_IN     number of input channels (>= 2)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   din        flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel        explicit channel select (mode=0 only)
//   mode       0 = explicit select, 1 = round-robin
//   in_valid   upstream offers a transfer
//   in_ready   block can accept a transfer this cycle
//   dout       registered data of the accepted channel
//   out_sel    index of the channel that produced dout
//   out_valid  dout/out_sel hold a valid entry
//   out_ready  downstream takes the entry this cycle
//   err_clr    synchronous clear of err
//   err        sticky out-of-range select flag
// -----------------------------------------------------------------------------
module pipe_mux #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        dout,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic                    err
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

    logic [WIDTH-1:0] r_dout;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_rr_ptr;
    logic             r_err;

    logic [SEL_W-1:0] w_ch;
    logic             w_in_range;
    logic [WIDTH-1:0] w_ch_data;
    logic             w_in_ready;
    logic             w_xfer;
    logic             w_accept;
    logic             w_drain;
    logic             w_bad_sel;

    assign w_ch = mode ? r_rr_ptr : sel;

    // With a power-of-two channel count every select encoding is a real
    // channel, so the range test collapses to a constant.
    if ((1 << SEL_W) == NUM_IN) begin : g_pow2
        assign w_in_range = 1'b1;
    end else begin : g_npow2
        assign w_in_range = (w_ch <= LAST_CH);
    end

    // NOTE: every signal written in always_comb gets a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_ch_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (w_ch == SEL_W'(k)) begin
                w_ch_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // The output register can take a new entry when it is empty or is being
    // emptied this same cycle; this gives one transfer per cycle.
    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_xfer     = in_valid & w_in_ready;
    assign w_accept   = w_xfer & w_in_range;
    assign w_drain    = r_out_valid & out_ready;
    assign w_bad_sel  = w_xfer & ~mode & ~w_in_range;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order. The reset branch
    // clears every register asynchronously; this block holds no memory array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout      <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dout      <= w_ch_data;
                r_out_sel   <= w_ch;
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                // Data and index keep their last values after the drain.
                r_out_valid <= 1'b0;
            end

            if (w_accept && mode) begin
                r_rr_ptr <= (r_rr_ptr == LAST_CH) ? '0 : r_rr_ptr + 1'b1;
            end

            // A fresh out-of-range attempt wins over a clear in the same cycle.
            if (w_bad_sel) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign dout      = r_dout;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_pipe_mux.sv
// -----------------------------------------------------------------------------
// tb_pipe_mux
//
// Self-checking bench for pipe_mux. A 4-channel instance is driven through
// explicit, round-robin, back-pressure, reset and mode-switch scenarios with a
// reference model and scoreboard queue; a 3-channel instance covers the
// out-of-range select, sticky error and round-robin wrap at a non-power-of-two
// channel count.
// -----------------------------------------------------------------------------
module tb_pipe_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [15:0] din;
    logic [1:0]  sel;
    logic        mode, in_valid, out_ready, err_clr;
    logic        in_ready, out_valid, err;
    logic [3:0]  dout;
    logic [1:0]  out_sel;

    // 3-channel instance
    logic [11:0] d3_din;
    logic [1:0]  d3_sel;
    logic        d3_mode, d3_in_valid, d3_out_ready, d3_err_clr;
    logic        d3_in_ready, d3_out_valid, d3_err;
    logic [3:0]  d3_dout;
    logic [1:0]  d3_out_sel;

    pipe_mux #(.WIDTH(4), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .dout(dout),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
        .err_clr(err_clr), .err(err)
    );

    pipe_mux #(.WIDTH(4), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst(rst), .din(d3_din), .sel(d3_sel), .mode(d3_mode),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .dout(d3_dout),
        .out_sel(d3_out_sel), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .err_clr(d3_err_clr), .err(d3_err)
    );

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] sel;
    } entry_t;

    entry_t exp_q[$];
    logic   m_valid;
    int     m_rr;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of the 4-channel instance: check outputs against the model at
    // the falling edge, then advance the model across the rising edge.
    task automatic step();
        logic   rdy, acc, drn;
        int     ch;
        entry_t e;
        @(negedge clk);
        check("in_ready", in_ready, !m_valid || out_ready);
        check("out_valid", out_valid, m_valid);
        check("err4", err, 1'b0);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                check("sb_dout", dout, exp_q[0].data);
                check("sb_out_sel", out_sel, exp_q[0].sel);
            end
        end
        rdy = !m_valid || out_ready;
        acc = in_valid && rdy;
        drn = m_valid && out_ready;
        ch  = mode ? m_rr : int'(sel);
        e.data = din[ch*4 +: 4];
        e.sel  = 2'(ch);
        @(posedge clk);
        #1;
        if (drn && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
        m_valid = acc || (m_valid && !drn);
        if (acc && mode) m_rr = (m_rr + 1) % 4;
    endtask

    initial begin
        logic [1:0] rr_sel [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] rr_dat [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB};
        logic [1:0] w3_sel [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [3:0] w3_dat [4] = '{4'h7, 4'h8, 4'h9, 4'h7};

        rst = 1'b0;
        din = '0; sel = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        d3_din = '0; d3_sel = '0; d3_mode = 1'b0; d3_in_valid = 1'b0;
        d3_out_ready = 1'b0; d3_err_clr = 1'b0;
        m_valid = 1'b0;
        m_rr    = 0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_dout", dout, 4'h0);
        check("rst_out_sel", out_sel, 2'd0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Explicit select, channel 2
        din = 16'hDCBA; sel = 2'd2; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        check("exp_dout", dout, 4'hC);
        check("exp_out_sel", out_sel, 2'd2);
        check("exp_out_valid", out_valid, 1'b1);

        // Round-robin, six back-to-back accepts
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_out_sel", out_sel, rr_sel[i]);
            check("rr_dout", dout, rr_dat[i]);
        end
        in_valid = 1'b0;

        // Asynchronous reset mid-cycle with an entry held and pointer at 2
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_dout", dout, 4'h0);
        check("arst_in_ready", in_ready, 1'b1);
        m_valid = 1'b0;
        m_rr    = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("arst_hold_valid", out_valid, 1'b0);
        rst = 1'b0;

        // First accept after reset uses round-robin index 0
        mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        check("post_rst_rr_sel", out_sel, 2'd0);
        check("post_rst_rr_dout", dout, 4'hA);

        // Drain with no new accept: valid drops, data holds
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 1'b0);
        check("drain_hold_dout", dout, 4'hA);

        // Back-pressure: hold entry while inputs toggle
        mode = 1'b0; sel = 2'd3; in_valid = 1'b1; out_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            din  = 16'($urandom);
            sel  = 2'(i);
            mode = 1'(i);
            step();
            check("bp_dout", dout, 4'hD);
            check("bp_out_sel", out_sel, 2'd3);
            check("bp_in_ready", in_ready, 1'b0);
        end
        din = 16'h5678; sel = 2'd1; mode = 1'b0; out_ready = 1'b1;
        step();
        check("bp_reload_valid", out_valid, 1'b1);
        check("bp_reload_dout", dout, 4'h7);
        check("bp_reload_sel", out_sel, 2'd1);

        // Mode 1 -> 0 -> 1: pointer holds across explicit accepts (now at 1)
        din = 16'hDCBA; mode = 1'b1;
        step();
        check("tog_rr1", out_sel, 2'd1);
        mode = 1'b0; sel = 2'd0;
        step();
        sel = 2'd3;
        step();
        mode = 1'b1;
        step();
        check("tog_resume_sel", out_sel, 2'd2);
        check("tog_resume_dout", dout, 4'hC);
        step();
        check("tog_next_sel", out_sel, 2'd3);
        in_valid = 1'b0;
        step();
        step();
        check("sb_empty", exp_q.size(), 0);

        // 3-channel instance: out-of-range select, sticky error, clear
        d3_din = 12'h987; d3_mode = 1'b0; d3_sel = 2'd3;
        d3_in_valid = 1'b1; d3_out_ready = 1'b1;
        @(posedge clk); #1;
        d3_in_valid = 1'b0;
        check("oor_out_valid", d3_out_valid, 1'b0);
        check("oor_err", d3_err, 1'b1);
        @(posedge clk); #1;
        check("oor_err_sticky", d3_err, 1'b1);
        d3_err_clr = 1'b1;
        @(posedge clk); #1;
        d3_err_clr = 1'b0;
        check("err_clear", d3_err, 1'b0);
        d3_in_valid = 1'b1; d3_err_clr = 1'b1;
        @(posedge clk); #1;
        d3_in_valid = 1'b0;
        check("err_set_wins", d3_err, 1'b1);
        @(posedge clk); #1;
        d3_err_clr = 1'b0;
        check("err_clear2", d3_err, 1'b0);

        d3_sel = 2'd2; d3_in_valid = 1'b1;
        @(posedge clk); #1;
        check("n3_dout", d3_dout, 4'h9);
        check("n3_out_sel", d3_out_sel, 2'd2);
        check("n3_err", d3_err, 1'b0);

        // 3-channel round-robin wraps after index 2
        d3_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("n3_rr_sel", d3_out_sel, w3_sel[i]);
            check("n3_rr_dout", d3_dout, w3_dat[i]);
        end
        d3_in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
